video_mode_ctrl: RTL and testbench

- Measures incoming Dreamcast sync timing (hsync/vsync) and classifies the video mode as 480p, 480i or 240p.
- Debounces mode changes over several frames, then drives the configuration inputs of the pixel-capture datapath: line_doubler, add_line and visible-area window.
- Sits between the raw sync inputs and the capture/line-doubler blocks, in the same clock domain as capture.

---
 rtl/video_mode_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_video_mode_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: measures Dreamcast hsync/vsync timing, classifies 480p / 480i / 240p,
// debounces over several frames and drives the capture datapath configuration.
module video_mode_ctrl #(
   parameter int STABLE_FRAMES = 4,
   parameter int LINE_TOL      = 16,
   parameter int LOST_FRAMES   = 2,
   parameter int LINE_480P     = 1716,  // clocks per 31 kHz line; 15 kHz lines are twice this
   parameter int FIELD_LINES   = 262    // short 15 kHz field; 480p frames span 2x..2x+2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        _hsync,
   input  logic        _vsync,
   input  logic [1:0]  force_mode,
   output logic [1:0]  mode,
   output logic        mode_valid,
   output logic        mode_changed,
   output logic        line_doubler,
   output logic        add_line,
   output logic [9:0]  hstart,
   output logic [9:0]  vstart,
   output logic [9:0]  width,
   output logic [9:0]  height,
   output logic [11:0] line_len,
   output logic [9:0]  frame_lines
);
   localparam logic [1:0]  M_NONE = 2'd0, M_480P = 2'd1, M_480I = 2'd2, M_240P = 2'd3;
   localparam logic [11:0] LP_LO  = 12'(LINE_480P - LINE_TOL);
   localparam logic [11:0] LP_HI  = 12'(LINE_480P + LINE_TOL);
   localparam logic [11:0] LI_LO  = 12'(2*LINE_480P - LINE_TOL);
   localparam logic [11:0] LI_HI  = 12'(2*LINE_480P + LINE_TOL);
   localparam logic [9:0]  F0     = 10'(FIELD_LINES);
   localparam logic [9:0]  F1     = 10'(FIELD_LINES + 1);
   localparam logic [9:0]  P_LO   = 10'(2*FIELD_LINES);
   localparam logic [9:0]  P_HI   = 10'(2*FIELD_LINES + 2);
   localparam logic [3:0]  STABLE = 4'(STABLE_FRAMES);
   localparam logic [3:0]  LOST   = 4'(LOST_FRAMES);

   typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

   // Bits [1:0] synchronize, bit [2] is the previous synchronized level for edge detect.
   logic [2:0] hs_sr, vs_sr;
   logic       hs_fall, vs_fall;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hs_sr   <= 3'b111;
         vs_sr   <= 3'b111;
         hs_fall <= 1'b0;
         vs_fall <= 1'b0;
      end else begin
         hs_sr   <= {hs_sr[1:0], _hsync};
         vs_sr   <= {vs_sr[1:0], _vsync};
         hs_fall <= hs_sr[2] & ~hs_sr[1];
         vs_fall <= vs_sr[2] & ~vs_sr[1];
      end
   end

   logic [11:0] line_cnt, l_now;
   logic [9:0]  fl_cnt, n_now, prev_lines;
   logic        armed, timeout;

   // Values as they stand after this cycle's hsync fall, so a coincident vsync sees it.
   always_comb begin
      l_now = line_len;
      n_now = fl_cnt;
      if (hs_fall) begin
         l_now = (line_cnt == 12'hFFF) ? 12'hFFF : line_cnt + 12'd1;
         n_now = (fl_cnt == 10'h3FF) ? fl_cnt : fl_cnt + 10'd1;
      end
   end

   assign timeout = !hs_fall && (line_cnt == 12'hFFE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         line_cnt    <= '0;
         line_len    <= '0;
         fl_cnt      <= '0;
         frame_lines <= '0;
         prev_lines  <= '0;
         armed       <= 1'b0;
      end else begin
         if (hs_fall) begin
            line_cnt <= '0;
            line_len <= l_now;
         end else if (line_cnt != 12'hFFF) begin
            line_cnt <= line_cnt + 12'd1;
         end
         if (vs_fall) begin
            fl_cnt <= '0;
            armed  <= 1'b1;
            if (armed) begin
               frame_lines <= n_now;
               prev_lines  <= n_now;
            end
         end else begin
            fl_cnt <= n_now;
         end
      end
   end

   logic       eval, cls_add;
   logic [1:0] cls;

   always_comb begin
      cls     = M_NONE;
      cls_add = 1'b0;
      eval    = (vs_fall && armed) || timeout;
      if (vs_fall && armed && !timeout && line_cnt != 12'hFFF) begin
         if (l_now >= LP_LO && l_now <= LP_HI && n_now >= P_LO && n_now <= P_HI) begin
            cls = M_480P;
         end else if (l_now >= LI_LO && l_now <= LI_HI && (n_now == F0 || n_now == F1)) begin
            // Alternating field lengths mean interlace; a repeated length is progressive.
            if (n_now != prev_lines && (prev_lines == F0 || prev_lines == F1)) begin
               cls = M_480I;
            end else begin
               cls     = M_240P;
               cls_add = (n_now == F1);
            end
         end
      end
   end

   state_t     state, state_nxt;
   logic [1:0] cand, cand_nxt, c_mode, c_mode_nxt;
   logic       cand_add, cand_add_nxt, c_add, c_add_nxt, c_valid, c_valid_nxt, commit;
   logic [3:0] cnt, cnt_nxt, lost, lost_nxt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= SEARCH;
         cand     <= M_NONE;
         cand_add <= 1'b0;
         cnt      <= '0;
         lost     <= '0;
         c_mode   <= M_NONE;
         c_add    <= 1'b0;
         c_valid  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cand     <= cand_nxt;
         cand_add <= cand_add_nxt;
         cnt      <= cnt_nxt;
         lost     <= lost_nxt;
         c_mode   <= c_mode_nxt;
         c_add    <= c_add_nxt;
         c_valid  <= c_valid_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cand_nxt     = cand;
      cand_add_nxt = cand_add;
      cnt_nxt      = cnt;
      lost_nxt     = lost;
      c_mode_nxt   = c_mode;
      c_add_nxt    = c_add;
      c_valid_nxt  = c_valid;
      commit       = 1'b0;
      if (eval) begin
         case (state)
            SEARCH: begin
               if (cls != M_NONE) begin
                  state_nxt    = CONFIRM;
                  cand_nxt     = cls;
                  cand_add_nxt = cls_add;
                  cnt_nxt      = 4'd1;
               end
            end
            CONFIRM: begin
               if (cls == M_NONE) begin
                  state_nxt = SEARCH;
               end else if (cls == cand && cls_add == cand_add) begin
                  cnt_nxt = cnt + 4'd1;
               end else begin
                  cand_nxt     = cls;
                  cand_add_nxt = cls_add;
                  cnt_nxt      = 4'd1;
               end
            end
            LOCKED: begin
               if (cls == M_NONE) begin
                  lost_nxt = lost + 4'd1;
                  if (lost_nxt >= LOST) begin
                     state_nxt   = SEARCH;
                     lost_nxt    = '0;
                     c_valid_nxt = 1'b0;
                  end
               end else if (cls == c_mode && cls_add == c_add) begin
                  lost_nxt = '0;
               end else begin
                  state_nxt    = CONFIRM;
                  cand_nxt     = cls;
                  cand_add_nxt = cls_add;
                  cnt_nxt      = 4'd1;
                  lost_nxt     = '0;
               end
            end
            default: state_nxt = SEARCH;
         endcase
         if (state_nxt == CONFIRM && cnt_nxt >= STABLE) begin
            commit      = 1'b1;
            state_nxt   = LOCKED;
            lost_nxt    = '0;
            c_mode_nxt  = cand_nxt;
            c_add_nxt   = cand_add_nxt;
            c_valid_nxt = 1'b1;
         end
      end
   end

   logic [1:0] o_mode;
   logic       o_add, o_valid;
   logic [9:0] w_h, w_v, w_w, w_ht;

   // Forcing overrides only the outputs; the committed state keeps tracking the input.
   always_comb begin
      o_mode  = c_mode_nxt;
      o_add   = c_add_nxt;
      o_valid = c_valid_nxt;
      if (force_mode != M_NONE) begin
         o_mode  = force_mode;
         o_add   = (force_mode == M_240P) && (frame_lines == F1);
         o_valid = 1'b1;
      end
      w_h  = 10'd257;
      w_v  = 10'd40;
      w_w  = 10'd720;
      w_ht = 10'd480;
      if (o_mode == M_480I || o_mode == M_240P) begin
         w_h  = o_add ? 10'd347 : 10'd327;
         w_v  = 10'd18;
         w_w  = 10'd643;
         w_ht = 10'd504;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mode         <= M_NONE;
         mode_valid   <= 1'b0;
         mode_changed <= 1'b0;
         line_doubler <= 1'b0;
         add_line     <= 1'b0;
         hstart       <= 10'd257;
         vstart       <= 10'd40;
         width        <= 10'd720;
         height       <= 10'd480;
      end else begin
         mode         <= o_mode;
         mode_valid   <= o_valid;
         mode_changed <= commit && (force_mode == M_NONE) && ({c_mode_nxt, c_add_nxt} != {c_mode, c_add});
         line_doubler <= (o_mode == M_480I) || (o_mode == M_240P);
         add_line     <= o_add;
         hstart       <= w_h;
         vstart       <= w_v;
         width        <= w_w;
         height       <= w_ht;
      end
   end
endmodule

// File: tb/tb_video_mode_ctrl.sv
// Scoreboard bench for video_mode_ctrl on scaled-down sync timing (60-clock lines, 12-line fields).
module tb_video_mode_ctrl;
   localparam int LP = 60;
   localparam int FL = 12;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        hsync_n = 1'b1;
   logic        vsync_n = 1'b1;
   logic [1:0]  force_mode = 2'd0;
   logic [1:0]  mode;
   logic        mode_valid, mode_changed, line_doubler, add_line;
   logic [9:0]  hstart, vstart, width, height, frame_lines;
   logic [11:0] line_len;

   int checks = 0;
   int errors = 0;
   logic [43:0] exp_q[$];
   logic [43:0] mon_exp, mon_act;

   always #5 clock = ~clock;

   video_mode_ctrl #(
      .STABLE_FRAMES(4), .LINE_TOL(4), .LOST_FRAMES(2), .LINE_480P(LP), .FIELD_LINES(FL)
   ) dut (
      .clock(clock), .reset(reset), ._hsync(hsync_n), ._vsync(vsync_n), .force_mode(force_mode),
      .mode(mode), .mode_valid(mode_valid), .mode_changed(mode_changed),
      .line_doubler(line_doubler), .add_line(add_line),
      .hstart(hstart), .vstart(vstart), .width(width), .height(height),
      .line_len(line_len), .frame_lines(frame_lines)
   );

   function automatic logic [43:0] pack(input logic [1:0] m, input logic a, input logic ld,
                                        input logic [9:0] hs, input logic [9:0] vs,
                                        input logic [9:0] w, input logic [9:0] h);
      return {m, a, ld, hs, vs, w, h};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_mode"}, mode, 0);
      check({tag, "_mode_valid"}, mode_valid, 0);
      check({tag, "_mode_changed"}, mode_changed, 0);
      check({tag, "_line_doubler"}, line_doubler, 0);
      check({tag, "_add_line"}, add_line, 0);
      check({tag, "_hstart"}, hstart, 257);
      check({tag, "_vstart"}, vstart, 40);
      check({tag, "_width"}, width, 720);
      check({tag, "_height"}, height, 480);
      check({tag, "_line_len"}, line_len, 0);
      check({tag, "_frame_lines"}, frame_lines, 0);
   endtask

   // Each frame opens with vsync falling together with the first hsync fall.
   task automatic send_frames(input int len, input int lines, input int count);
      for (int f = 0; f < count; f++) begin
         for (int l = 0; l < lines; l++) begin
            hsync_n = 1'b0;
            if (l == 0) vsync_n = 1'b0;
            if (l == 3) vsync_n = 1'b1;
            repeat (4) @(posedge clock);
            #1 hsync_n = 1'b1;
            repeat (len - 4) @(posedge clock);
            #1;
         end
      end
   endtask

   task automatic vsync_only(input int idle);
      vsync_n = 1'b0;
      repeat (20) @(posedge clock);
      #1 vsync_n = 1'b1;
      repeat (idle - 20) @(posedge clock);
      #1;
   endtask

   task automatic pulse_reset();
      #1 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
   endtask

   // Every mode_changed pulse must match the next queued commit.
   always @(negedge clock) begin
      if (reset && mode_changed) begin
         checks++;
         mon_act = pack(mode, add_line, line_doubler, hstart, vstart, width, height);
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_commit: got mode=%0d add_line=%0d, expected no mode_changed", mode, add_line);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               errors++;
               $display("FAIL commit_outputs: got %h, expected %h", mon_act, mon_exp);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clock);
      #1 check_reset_state("reset");
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      // 480p: the first vsync only arms, so 4 frames give 3 evaluations
      send_frames(LP, 25, 4);
      check("480p_before_4th_eval", mode_valid, 0);
      exp_q.push_back(pack(2'd1, 1'b0, 1'b0, 10'd257, 10'd40, 10'd720, 10'd480));
      send_frames(LP, 25, 1);
      check("480p_mode", mode, 1);
      check("480p_valid", mode_valid, 1);
      check("480p_line_doubler", line_doubler, 0);
      check("480p_line_len", line_len, LP);
      check("480p_frame_lines", frame_lines, 25);

      // 240p with 263-line (scaled 13) frames
      exp_q.push_back(pack(2'd3, 1'b1, 1'b1, 10'd347, 10'd18, 10'd643, 10'd504));
      send_frames(2*LP, FL+1, 4);
      check("240p_hold_old_mode", mode, 1);
      send_frames(2*LP, FL+1, 1);
      check("240p_mode", mode, 3);
      check("240p_add_line", add_line, 1);
      check("240p_hstart", hstart, 347);
      check("240p_frame_lines", frame_lines, FL+1);

      // 262-line frames: one 480i-looking transition, then 4 matching frames
      exp_q.push_back(pack(2'd3, 1'b0, 1'b1, 10'd327, 10'd18, 10'd643, 10'd504));
      send_frames(2*LP, FL, 6);
      check("240p262_add_line", add_line, 0);
      check("240p262_hstart", hstart, 327);

      // 480i: alternating field lengths
      exp_q.push_back(pack(2'd2, 1'b0, 1'b1, 10'd327, 10'd18, 10'd643, 10'd504));
      for (int i = 0; i < 3; i++) begin
         send_frames(2*LP, FL+1, 1);
         send_frames(2*LP, FL, 1);
      end
      check("480i_mode", mode, 2);
      check("480i_line_doubler", line_doubler, 1);
      check("480i_add_line", add_line, 0);
      check("480i_vstart", vstart, 18);
      check("480i_height", height, 504);

      // Loss of lock: hsync stops, one timeout then one empty frame
      pulse_reset();
      exp_q.push_back(pack(2'd1, 1'b0, 1'b0, 10'd257, 10'd40, 10'd720, 10'd480));
      send_frames(LP, 25, 6);
      check("relock_valid", mode_valid, 1);
      vsync_only(4300);
      check("one_loss_still_valid", mode_valid, 1);
      vsync_only(100);
      check("lost_valid_cleared", mode_valid, 0);
      check("lost_mode_holds", mode, 1);
      check("lost_hstart_holds", hstart, 257);

      // Glitch frame restarts the stability count
      pulse_reset();
      send_frames(LP, 25, 3);
      send_frames(LP + 6, 25, 1);
      check("glitch_no_commit_before", mode_valid, 0);
      send_frames(LP, 25, 4);
      check("glitch_no_commit_3_after", mode_valid, 0);
      exp_q.push_back(pack(2'd1, 1'b0, 1'b0, 10'd257, 10'd40, 10'd720, 10'd480));
      send_frames(LP, 25, 1);
      check("glitch_commit_4_after", mode_valid, 1);

      // Forced 240p, then back to auto without a pulse
      force_mode = 2'd3;
      @(posedge clock);
      #1;
      check("force_mode", mode, 3);
      check("force_line_doubler", line_doubler, 1);
      check("force_valid", mode_valid, 1);
      check("force_add_line", add_line, 0);
      check("force_hstart", hstart, 327);
      force_mode = 2'd0;
      @(posedge clock);
      #1;
      check("unforce_mode", mode, 1);
      check("unforce_line_doubler", line_doubler, 0);
      check("unforce_hstart", hstart, 257);
      check("unforce_valid", mode_valid, 1);

      // Reset in the middle of a frame
      fork
         send_frames(LP, 25, 1);
      join_none
      repeat (700) @(posedge clock);
      #3 reset = 1'b0;
      #1 check_reset_state("midframe");
      repeat (900) @(posedge clock);
      #1 reset = 1'b1;
      repeat (10) @(posedge clock);
      #1 check("pending_commits", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
